// File: rtl/nios_qsys_nios2_gen2_cpu_mul_seq_pkg.sv
// Shared definitions for the multiplier sequencer: op codes, FSM states and the
// half-word width used to split operands for the 16x16 cell.
package nios_qsys_nios2_gen2_cpu_mul_seq_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXSS = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ISSUE1 = 4'd1,
    WAIT1  = 4'd2,
    CAP1   = 4'd3,
    ISSUE2 = 4'd4,
    WAIT2  = 4'd5,
    CAP2   = 4'd6,
    SUM    = 4'd7,
    DONE   = 4'd8
  } state_e;

endpackage

// File: rtl/nios_qsys_nios2_gen2_cpu_mul_seq_if.sv
// Bundle of request, cell and result signals around the multiplier sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; the
// source holds valid and payload stable until then, and never waits on ready.
interface nios_qsys_nios2_gen2_cpu_mul_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;

  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, cell_p1, cell_p2, cell_p3, out_ready,
    output in_ready, cell_src1, cell_src2, cell_en, out_valid, out_result
  );

  modport master (
    output in_valid, in_op, in_src1, in_src2, cell_p1, cell_p2, cell_p3, out_ready,
    input  in_ready, cell_src1, cell_src2, cell_en, out_valid, out_result
  );

endinterface

// File: rtl/nios_qsys_nios2_gen2_cpu_mul_combine.sv
// Combinational adder tree for the 16x16 partials plus the signed correction
// that turns an unsigned 64-bit product into the signed high word.
module nios_qsys_nios2_gen2_cpu_mul_combine
  import nios_qsys_nios2_gen2_cpu_mul_seq_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] p1_i,
  input  logic [31:0] p2_i,
  input  logic [31:0] p3_i,
  input  logic [31:0] hh_i,
  input  logic        a_sign_i,
  input  logic        b_sign_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  logic [32:0] mid;
  logic [63:0] full;
  logic [31:0] hi;
  logic [31:0] corr_a;
  logic [31:0] corr_b;

  always_comb begin
    mid    = {1'b0, p2_i} + {1'b0, p3_i};
    full   = {32'h0, p1_i} + ({31'h0, mid} << HALF_W) + {hh_i, 32'h0};
    hi     = full[63:32];
    // Two's-complement operand read as unsigned adds 2^32*other; subtract it back.
    corr_a = a_sign_i ? b_i : 32'h0;
    corr_b = b_sign_i ? a_i : 32'h0;
    case (op_i)
      OP_MUL:    result_o = full[31:0];
      OP_MULXUU: result_o = hi;
      OP_MULXSU: result_o = hi - corr_a;
      default:   result_o = hi - corr_a - corr_b;
    endcase
  end

endmodule

// File: rtl/nios_qsys_nios2_gen2_cpu_mul_seq.sv
// Sequencer driving a registered 16x16 multiplier cell: one pass for the low
// word, a second hi*hi pass for high-word ops, then combine and hand off.
module nios_qsys_nios2_gen2_cpu_mul_seq
  import nios_qsys_nios2_gen2_cpu_mul_seq_pkg::*;
#(
  parameter int CELL_LATENCY = 1
) (
  input  logic   clk,
  input  logic   reset,
  nios_qsys_nios2_gen2_cpu_mul_seq_if.slave bus,
  output state_e state_o
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CELL_LATENCY - 1);
  localparam bit HAS_WAIT = (CELL_LATENCY > 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, hh_q, hh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       comb_result;
  logic              cell_en_c;
  logic [31:0]       cell_src1_c, cell_src2_c;

  nios_qsys_nios2_gen2_cpu_mul_combine u_combine (
    .op_i     (op_q),
    .p1_i     (p1_q),
    .p2_i     (p2_q),
    .p3_i     (p3_q),
    .hh_i     (hh_q),
    .a_sign_i (a_q[31]),
    .b_sign_i (b_q[31]),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (comb_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      p3_q     <= '0;
      hh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      p3_q     <= p3_d;
      hh_q     <= hh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    hh_d        = hh_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    cell_en_c   = 1'b0;
    cell_src1_c = '0;
    cell_src2_c = '0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          a_d     = bus.in_src1;
          b_d     = bus.in_src2;
          state_d = ISSUE1;
        end
      end
      ISSUE1: begin
        cell_en_c   = 1'b1;
        cell_src1_c = a_q;
        cell_src2_c = b_q;
        cnt_d       = WAIT_LOAD;
        state_d     = HAS_WAIT ? WAIT1 : CAP1;
      end
      WAIT1: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = CAP1;
      end
      CAP1: begin
        p1_d    = bus.cell_p1;
        p2_d    = bus.cell_p2;
        p3_d    = bus.cell_p3;
        state_d = (op_q == OP_MUL) ? SUM : ISSUE2;
      end
      ISSUE2: begin
        cell_en_c   = 1'b1;
        cell_src1_c = {16'h0, a_q[31:HALF_W]};
        cell_src2_c = {16'h0, b_q[31:HALF_W]};
        cnt_d       = WAIT_LOAD;
        state_d     = HAS_WAIT ? WAIT2 : CAP2;
      end
      WAIT2: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = CAP2;
      end
      CAP2: begin
        hh_d    = bus.cell_p1;
        state_d = SUM;
      end
      SUM: begin
        result_d = comb_result;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.cell_en    = cell_en_c;
  assign bus.cell_src1  = cell_src1_c;
  assign bus.cell_src2  = cell_src2_c;
  assign state_o        = state_q;

endmodule

// File: tb/tb_nios_qsys_nios2_gen2_cpu_mul_seq.sv
// Bench for the multiplier sequencer: two instances (cell latency 1 and 3) with
// behavioural cell models, directed and random ops, scoreboard-based checking.
module tb_nios_qsys_nios2_gen2_cpu_mul_seq;
  import nios_qsys_nios2_gen2_cpu_mul_seq_pkg::*;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nios_qsys_nios2_gen2_cpu_mul_seq_if bus ();
  nios_qsys_nios2_gen2_cpu_mul_seq_if bus3 ();
  state_e st, st3;

  nios_qsys_nios2_gen2_cpu_mul_seq #(.CELL_LATENCY(LAT1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .state_o(st)
  );
  nios_qsys_nios2_gen2_cpu_mul_seq #(.CELL_LATENCY(LAT3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .state_o(st3)
  );

  // ---------------- reference models ----------------
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [63:0] prod;
    sa   = (op == OP_MULXSU || op == OP_MULXSS) ? longint'(signed'(a)) : longint'({32'h0, a});
    sb   = (op == OP_MULXSS) ? longint'(signed'(b)) : longint'({32'h0, b});
    prod = 64'(sa * sb);
    return (op == OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic logic [95:0] cell_prods(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p1, p2, p3;
    p1 = 32'(a[15:0])  * 32'(b[15:0]);
    p2 = 32'(a[15:0])  * 32'(b[31:16]);
    p3 = 32'(a[31:16]) * 32'(b[15:0]);
    return {p1, p2, p3};
  endfunction

  // Cell models: products appear LAT cycles after an enable and are then held.
  logic        pv1 [1:4];
  logic [95:0] pipe1 [1:4];
  logic [95:0] hold1, cell1;
  always @(posedge clk) begin
    pv1[1]   <= bus.cell_en;
    pipe1[1] <= cell_prods(bus.cell_src1, bus.cell_src2);
    for (int i = 2; i <= 4; i++) begin
      pv1[i]   <= pv1[i-1];
      pipe1[i] <= pipe1[i-1];
    end
    if (pv1[LAT1]) hold1 <= pipe1[LAT1];
  end
  assign cell1 = pv1[LAT1] ? pipe1[LAT1] : hold1;
  assign bus.cell_p1 = cell1[95:64];
  assign bus.cell_p2 = cell1[63:32];
  assign bus.cell_p3 = cell1[31:0];

  logic        pv3 [1:4];
  logic [95:0] pipe3 [1:4];
  logic [95:0] hold3, cell3;
  always @(posedge clk) begin
    pv3[1]   <= bus3.cell_en;
    pipe3[1] <= cell_prods(bus3.cell_src1, bus3.cell_src2);
    for (int i = 2; i <= 4; i++) begin
      pv3[i]   <= pv3[i-1];
      pipe3[i] <= pipe3[i-1];
    end
    if (pv3[LAT3]) hold3 <= pipe3[LAT3];
  end
  assign cell3 = pv3[LAT3] ? pipe3[LAT3] : hold3;
  assign bus3.cell_p1 = cell3[95:64];
  assign bus3.cell_p2 = cell3[63:32];
  assign bus3.cell_p3 = cell3[31:0];

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_en_q[$];
  logic [31:0] exp3_q[$];
  int          exp3_cyc_q[$];

  logic [31:0] cur_a, cur_b;
  int  en_count = 0;
  int  adj = 0;
  logic prev_en = 1'b0;
  logic valid_prev = 1'b0;
  logic hs_prev = 1'b0;
  logic valid3_prev = 1'b0;
  int  ready_mode = 2;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input int lane, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    int lat;
    @(negedge clk);
    if (lane == 0) begin
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_src1 = a; bus.in_src2 = b;
    end else begin
      bus3.in_valid = 1'b1; bus3.in_op = op; bus3.in_src1 = a; bus3.in_src2 = b;
    end
    n = 0;
    while (((lane == 0) ? !bus.in_ready : !bus3.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      flag_fail("accept_timeout");
    end else begin
      lat = (op == OP_MUL) ? 4 : 6;
      lat += ((op == OP_MUL) ? 1 : 2) * (((lane == 0) ? LAT1 : LAT3) - 1);
      if (lane == 0) begin
        cur_a = a; cur_b = b; en_count = 0; adj = 0;
        exp_q.push_back(ref_mul(op, a, b));
        exp_cyc_q.push_back(cyc + lat);
        exp_en_q.push_back((op == OP_MUL) ? 1 : 2);
      end else begin
        exp3_q.push_back(ref_mul(op, a, b));
        exp3_cyc_q.push_back(cyc + lat);
      end
    end
    @(negedge clk);
    if (lane == 0) begin
      bus.in_valid = 1'b0; bus.in_src1 = $urandom; bus.in_src2 = $urandom;
    end else begin
      bus3.in_valid = 1'b0; bus3.in_src1 = $urandom; bus3.in_src2 = $urandom;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp3_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) flag_fail("drain_timeout");
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0000;
      3:       return 32'(($urandom_range(0, 1) << 31) | $urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  // out_ready changes just after the active edge so it is stable at the negedge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitors ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.cell_en) begin
          if (prev_en) adj = 1;
          if (en_count == 0) begin
            check("issue1_src1", bus.cell_src1, cur_a);
            check("issue1_src2", bus.cell_src2, cur_b);
          end else begin
            check("issue2_src1", bus.cell_src1, {16'h0, cur_a[31:16]});
            check("issue2_src2", bus.cell_src2, {16'h0, cur_b[31:16]});
          end
          en_count++;
        end else begin
          check("idle_cell_src", bus.cell_src1 | bus.cell_src2, 32'h0);
        end
        prev_en = bus.cell_en;
        if (hs_prev) begin
          check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
          check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        end
        hs_prev = 1'b0;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            flag_fail("unexpected_out_valid");
          end else begin
            if (!valid_prev) check("latency", 32'(cyc), 32'(exp_cyc_q[0]));
            check("result", bus.out_result, exp_q[0]);
            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            if (bus.out_ready) begin
              check("cell_en_count", 32'(en_count), 32'(exp_en_q[0]));
              check("cell_en_adjacent", 32'(adj), 32'd0);
              void'(exp_q.pop_front());
              void'(exp_cyc_q.pop_front());
              void'(exp_en_q.pop_front());
              hs_prev = 1'b1;
            end
          end
        end
        valid_prev = bus.out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus3.out_valid) begin
        if (exp3_q.size() == 0) begin
          flag_fail("lat3_unexpected_out_valid");
        end else begin
          if (!valid3_prev) check("lat3_latency", 32'(cyc), 32'(exp3_cyc_q[0]));
          check("lat3_result", bus3.out_result, exp3_q[0]);
          if (bus3.out_ready) begin
            void'(exp3_q.pop_front());
            void'(exp3_cyc_q.pop_front());
          end
        end
      end
      valid3_prev = bus3.out_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 2'd0; bus.in_src1 = '0; bus.in_src2 = '0;
    bus3.in_valid = 1'b0; bus3.in_op = 2'd0; bus3.in_src1 = '0; bus3.in_src2 = '0;
    bus3.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(st), 32'(IDLE));
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'h0);
    check("rst_cell_en", 32'(bus.cell_en), 32'd0);
    check("rst_cell_src", bus.cell_src1 | bus.cell_src2, 32'h0);
    reset = 1'b0;

    issue(0, OP_MUL,    32'h0001_0003, 32'h0002_0005);
    issue(0, OP_MULXUU, 32'h0001_0003, 32'h0002_0005);
    issue(0, OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(0, OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(0, OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Result must hold while the consumer stalls.
    ready_mode = 1;
    issue(0, OP_MUL, 32'h1234_5678, 32'h0000_0010);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) flag_fail("stall_valid_timeout");
    repeat (5) @(negedge clk);
    ready_mode = 2;
    drain();

    // Reset during the second pass abandons the op.
    issue(0, OP_MULXSS, 32'hDEAD_BEEF, 32'h8765_4321);
    repeat (2) @(negedge clk);
    check("pre_reset_state", 32'(st), 32'(ISSUE2));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_state", 32'(st), 32'(IDLE));
    check("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_reset_cell_en", 32'(bus.cell_en), 32'd0);
    check("mid_reset_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete(); exp_cyc_q.delete(); exp_en_q.delete();
    issue(0, OP_MUL, 32'd3, 32'd5);
    drain();

    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      issue(0, 2'($urandom_range(0, 3)), rand_word(), rand_word());
    end
    ready_mode = 2;
    drain();

    issue(1, OP_MULXSS, 32'h8000_0000, 32'h0000_0002);
    for (int i = 0; i < 10; i++) begin
      issue(1, 2'($urandom_range(0, 3)), rand_word(), rand_word());
    end
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
